// File: rtl/tie_fanout_pkg.sv
// Package: tie_fanout_pkg
// Elaboration-time geometry helpers for the registered tie/broadcast fanout tree.
//   clog2(value)              : bits needed to hold 0..value-1, never less than 1
//   tree_levels(n, f)         : tree depth L = max(1, ceil(log_f(n)))
//   level_count(n, f, k)      : registers at level k = ceil(n / f^(L-k))
//   level_base(n, f, k)       : register offset of level k (k >= 1) inside the
//                               packed vector that holds levels 1..L back to back
package tie_fanout_pkg;

    function automatic int clog2(input int value);
        int result;
        int cap;
        result = 32'sd0;
        cap    = 32'sd1;
        while (cap < value) begin
            cap    = cap * 32'sd2;
            result = result + 32'sd1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end
        return result;
    endfunction

    function automatic int tree_levels(input int n, input int f);
        int levels;
        int cap;
        levels = 32'sd0;
        cap    = 32'sd1;
        while (cap < n) begin
            cap    = cap * f;
            levels = levels + 32'sd1;
        end
        // A tree always has a root and a separate leaf level.
        if (levels < 32'sd1) begin
            levels = 32'sd1;
        end
        return levels;
    endfunction

    function automatic int level_count(input int n, input int f, input int k);
        int levels;
        int divisor;
        levels  = tree_levels(n, f);
        divisor = 32'sd1;
        for (int i = 32'sd0; i < levels - k; i++) begin
            divisor = divisor * f;
        end
        return (n + divisor - 32'sd1) / divisor;
    endfunction

    function automatic int level_base(input int n, input int f, input int k);
        int base;
        base = 32'sd0;
        for (int j = 32'sd1; j < k; j++) begin
            base = base + level_count(n, f, j);
        end
        return base;
    endfunction

endpackage

// File: rtl/tie_fanout_stage.sv
// Module: tie_fanout_stage
// One level of the fanout tree: N_OUT registers, each copying parent register
// (i / MAX_FANOUT) of the level above on every clock edge. Because the parent
// index is an integer divide, no parent ever feeds more than MAX_FANOUT children
// and only the last parent may feed fewer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (loads RESET_VALUE)
//   parent_data  : N_IN packed copies from the level above
//   child_data   : N_OUT packed copies produced by this level
module tie_fanout_stage #(
    parameter int               WIDTH       = 1,
    parameter int               N_IN        = 1,
    parameter int               N_OUT       = 1,
    parameter int               MAX_FANOUT  = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*WIDTH-1:0]  parent_data,
    output logic [N_OUT*WIDTH-1:0] child_data
);

    for (genvar i = 0; i < N_OUT; i++) begin : g_reg
        localparam int PARENT = i / MAX_FANOUT;

        logic [WIDTH-1:0] copy_r;

        // Unconditional copy of the parent: the tree is a pure shift pipeline.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                copy_r <= RESET_VALUE;
            end else begin
                copy_r <= parent_data[PARENT*WIDTH +: WIDTH];
            end
        end

        assign child_data[i*WIDTH +: WIDTH] = copy_r;
    end

endmodule

// File: rtl/tie_fanout_tree.sv
// Module: tie_fanout_tree
// Registered, fanout-bounded distribution of a tie/broadcast value to N_LOADS
// leaf copies. After reset every register holds RESET_VALUE; a new value can be
// loaded into the root through a valid/ready handshake and then ripples down one
// level per clock, reaching the leaves L edges after the accepting edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : new value offered
//   in_ready   : root can accept (combinational, equals !lock)
//   in_data    : value to distribute
//   lock       : freeze input; tree keeps shifting what is already in flight
//   out_data   : leaf copies, copy i at [i*WIDTH +: WIDTH]
//   settled    : every leaf equals the last accepted value
module tie_fanout_tree
    import tie_fanout_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               N_LOADS     = 102,
    parameter int               MAX_FANOUT  = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     lock,
    output logic [N_LOADS*WIDTH-1:0] out_data,
    output logic                     settled
);

    localparam int LEVELS    = tree_levels(N_LOADS, MAX_FANOUT);
    localparam int REMAIN_W  = clog2(LEVELS + 32'sd1);
    localparam int TREE_BITS = level_base(N_LOADS, MAX_FANOUT, LEVELS + 32'sd1) * WIDTH;
    localparam int LEAF_BASE = level_base(N_LOADS, MAX_FANOUT, LEVELS) * WIDTH;
    localparam logic [REMAIN_W-1:0] REMAIN_LOAD = REMAIN_W'(LEVELS);
    localparam logic [REMAIN_W-1:0] REMAIN_ZERO = {REMAIN_W{1'b0}};
    localparam logic [REMAIN_W-1:0] REMAIN_ONE  = REMAIN_W'(32'sd1);

    logic                  accept_s;
    logic [WIDTH-1:0]      root_r;
    logic [TREE_BITS-1:0]  tree_s;
    logic [REMAIN_W-1:0]   remain_r;
    logic [REMAIN_W-1:0]   remain_next_s;
    logic                  settled_r;

    assign in_ready = !lock;
    assign accept_s = in_valid && !lock;

    // Root register: the only place a new value enters the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_r <= RESET_VALUE;
        end else if (accept_s) begin
            root_r <= in_data;
        end else begin
            root_r <= root_r;
        end
    end

    // Levels 1..L are packed back to back in tree_s; the last level is the leaves.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int N_IN     = level_count(N_LOADS, MAX_FANOUT, k - 32'sd1);
        localparam int N_OUT    = level_count(N_LOADS, MAX_FANOUT, k);
        localparam int OUT_BASE = level_base(N_LOADS, MAX_FANOUT, k) * WIDTH;

        logic [N_IN*WIDTH-1:0] parent_s;

        if (k == 32'sd1) begin : g_from_root
            assign parent_s = root_r;
        end else begin : g_from_level
            assign parent_s = tree_s[level_base(N_LOADS, MAX_FANOUT, k - 32'sd1) * WIDTH +: N_IN*WIDTH];
        end

        tie_fanout_stage #(
            .WIDTH       (WIDTH),
            .N_IN        (N_IN),
            .N_OUT       (N_OUT),
            .MAX_FANOUT  (MAX_FANOUT),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .parent_data (parent_s),
            .child_data  (tree_s[OUT_BASE +: N_OUT*WIDTH])
        );
    end

    // Settle window: reload on every accept, otherwise count down to zero.
    always_comb begin
        remain_next_s = remain_r;
        if (accept_s) begin
            remain_next_s = REMAIN_LOAD;
        end else if (remain_r != REMAIN_ZERO) begin
            remain_next_s = remain_r - REMAIN_ONE;
        end else begin
            remain_next_s = remain_r;
        end
    end

    // settled is registered from the next count so it changes on the same edge
    // that the counter reaches zero, in step with the leaves updating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_r  <= REMAIN_ZERO;
            settled_r <= 1'b1;
        end else begin
            remain_r  <= remain_next_s;
            settled_r <= (remain_next_s == REMAIN_ZERO);
        end
    end

    assign out_data = tree_s[LEAF_BASE +: N_LOADS*WIDTH];
    assign settled  = settled_r;

endmodule

// File: tb/tb_tie_fanout_tree.sv
module tb_tie_fanout_tree;

    localparam int WIDTH   = 1;
    localparam int N_LOADS = 102;
    localparam int LEVELS  = 3;   // ceil(log10(102))

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic               lock     = 1'b0;
    logic [WIDTH-1:0]   in_data  = 1'b0;
    wire                in_ready;
    wire  [N_LOADS*WIDTH-1:0] out_data;
    wire                settled;

    int errors = 0;
    int checks = 0;

    tie_fanout_tree u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .lock     (lock),
        .out_data (out_data),
        .settled  (settled)
    );

    // Geometry sweep instances
    logic [3:0] sw_valid = 4'b0000;
    logic [7:0] sw_data  = 8'h00;
    wire  [0:0]   sw_out0;
    wire  [39:0]  sw_out1;
    wire  [43:0]  sw_out2;
    wire  [511:0] sw_out3;
    wire  [3:0]   sw_settled;
    wire  [3:0]   sw_ready;

    tie_fanout_tree #(.WIDTH(1), .N_LOADS(1), .MAX_FANOUT(2)) u_sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[0]), .in_ready(sw_ready[0]),
        .in_data(sw_data[0:0]), .lock(1'b0), .out_data(sw_out0), .settled(sw_settled[0]));
    tie_fanout_tree #(.WIDTH(4), .N_LOADS(10), .MAX_FANOUT(10)) u_sw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[1]), .in_ready(sw_ready[1]),
        .in_data(sw_data[3:0]), .lock(1'b0), .out_data(sw_out1), .settled(sw_settled[1]));
    tie_fanout_tree #(.WIDTH(4), .N_LOADS(11), .MAX_FANOUT(10)) u_sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[2]), .in_ready(sw_ready[2]),
        .in_data(sw_data[3:0]), .lock(1'b0), .out_data(sw_out2), .settled(sw_settled[2]));
    tie_fanout_tree #(.WIDTH(8), .N_LOADS(64), .MAX_FANOUT(4)) u_sw3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid[3]), .in_ready(sw_ready[3]),
        .in_data(sw_data), .lock(1'b0), .out_data(sw_out3), .settled(sw_settled[3]));

    // Reference model: the leaves show whatever the root held LEVELS edges ago,
    // and the tree is settled once LEVELS edges have passed since the last accept.
    typedef struct {
        logic [WIDTH-1:0] leaf;
        logic             settled;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] root_hist[$];
    int               since_accept;

    initial begin
        exp_t             e;
        logic             acc;
        logic [WIDTH-1:0] new_root;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                root_hist = {};
                for (int i = 0; i <= LEVELS; i++) root_hist.push_back(1'b1);
                since_accept = LEVELS;
                sb_q = {};
            end else begin
                acc      = in_valid && !lock;
                new_root = acc ? in_data : root_hist[0];
                root_hist.push_front(new_root);
                void'(root_hist.pop_back());
                if (acc) since_accept = 0;
                else if (since_accept < LEVELS) since_accept = since_accept + 1;
            end
            e.leaf    = root_hist[LEVELS];
            e.settled = (since_accept >= LEVELS);
            sb_q.push_back(e);
        end
    end

    // Monitor: every falling edge the DUT presents leaves/settled/in_ready.
    initial begin
        exp_t e;
        logic [N_LOADS*WIDTH-1:0] exp_leaves;
        forever begin
            @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t got=0 entries exp=1 entry", $time);
            end else begin
                e = sb_q.pop_front();
                exp_leaves = {N_LOADS{e.leaf}};
                if (out_data !== exp_leaves) begin
                    errors++;
                    $display("FAIL leaves t=%0t got=%h exp=%h", $time, out_data, exp_leaves);
                end
                checks++;
                if (settled !== e.settled) begin
                    errors++;
                    $display("FAIL settled t=%0t got=%0b exp=%0b", $time, settled, e.settled);
                end
                checks++;
                if (in_ready !== !lock) begin
                    errors++;
                    $display("FAIL in_ready t=%0t got=%0b exp=%0b", $time, in_ready, !lock);
                end
            end
        end
    end

    task automatic step(input logic v, input logic d, input logic lk);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        lock     = lk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic all_eq(input logic [511:0] v, input int n, input int w,
                                    input logic [7:0] d);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < w; b++)
                if (v[i*w + b] !== d[b]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sweep(input int j, input int w, input int n, input int lat);
        logic [7:0]   d;
        logic [511:0] v;
        logic         s;
        logic         exp_done;
        d = 8'($urandom) & 8'hFE;   // bit 0 clear: always differs from all-ones
        @(posedge clk);
        #1;
        sw_valid[j] = 1'b1;
        sw_data     = d;
        @(posedge clk);             // accepting edge
        #1;
        sw_valid[j] = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            v = '0;
            case (j)
                0: v[0:0]    = sw_out0;
                1: v[39:0]   = sw_out1;
                2: v[43:0]   = sw_out2;
                default: v   = sw_out3;
            endcase
            s        = sw_settled[j];
            exp_done = (c >= lat);
            checks++;
            if (all_eq(v, n, w, d) !== exp_done) begin
                errors++;
                $display("FAIL sweep%0d_leaves edge+%0d got_match=%0b exp_match=%0b",
                         j, c, all_eq(v, n, w, d), exp_done);
            end
            checks++;
            if (s !== exp_done) begin
                errors++;
                $display("FAIL sweep%0d_settled edge+%0d got=%0b exp=%0b", j, c, s, exp_done);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single load of 0
        step(1'b1, 1'b0, 1'b0);
        idle(5);

        // Back-to-back 0, 1, 0
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(6);

        // Lock: restore 1, then offer 0 while locked
        step(1'b1, 1'b1, 1'b0);
        idle(5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        // Accept 0 one edge before locking; it must still arrive
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        idle(5);

        // Mid-flight reset one edge after an accept
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset_pulse();
        idle(5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset_pulse();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) == 0));
            end
        end
        idle(5);

        // Geometry sweep: latencies 1, 1, 2, 3
        sweep(0, 1, 1, 1);
        sweep(1, 4, 10, 1);
        sweep(2, 4, 11, 2);
        sweep(3, 8, 64, 3);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
